// File: rtl/mshr_pkg.sv
// Shared geometry and entry layout for the MSHR file and its fill sequencer.
package mshr_pkg;

  localparam int unsigned ADDR_WIDTH_D     = 16;
  localparam int unsigned DATA_WIDTH_D     = 32;
  localparam int unsigned NUM_BLOCKS_D     = 8;
  localparam int unsigned NUM_OPS_D        = 32;
  localparam int unsigned NUM_ENTRIES_D    = 4;
  localparam int unsigned NUM_SUBENTRIES_D = 4;

  localparam int unsigned OPW  = $clog2(NUM_OPS_D);
  localparam int unsigned IDXW = $clog2(NUM_BLOCKS_D);
  localparam int unsigned TAGW = ADDR_WIDTH_D - IDXW;
  localparam int unsigned CNTW = $clog2(NUM_SUBENTRIES_D + 1);
  localparam int unsigned SUBW = $clog2(NUM_SUBENTRIES_D);

  typedef struct packed {
    logic                                valid;
    logic                                issued;
    logic [TAGW-1:0]                     tag;
    logic [IDXW-1:0]                     index;
    logic [CNTW-1:0]                     count;
    logic [NUM_SUBENTRIES_D-1:0][OPW-1:0] sub;
  } mshr_entry_t;

  typedef enum logic {
    FILL_IDLE,
    FILL_DRAIN
  } fill_state_t;

endpackage

// File: rtl/mshr_fill_fsm.sv
// Latches one memory response and replays one cache fill per merged op,
// then strobes the entry free.
module mshr_fill_fsm
  import mshr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = ADDR_WIDTH_D,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_D,
  parameter int unsigned NUM_ENTRIES = NUM_ENTRIES_D
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_resp_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0] i_resp_id,
  input  logic [DATA_WIDTH-1:0]          i_resp_data,
  output logic                           o_resp_ready,
  output logic [$clog2(NUM_ENTRIES)-1:0] o_rd_id,
  input  mshr_entry_t                    i_rd_entry,
  output logic                           o_busy,
  output logic                           o_free_stb,
  output logic                           o_fill_valid,
  output logic [ADDR_WIDTH-1:0]          o_fill_addr,
  output logic [OPW-1:0]                 o_fill_op,
  output logic [DATA_WIDTH-1:0]          o_fill_data
);

  fill_state_t                    r_state;
  logic [$clog2(NUM_ENTRIES)-1:0] r_id;
  logic [DATA_WIDTH-1:0]          r_data;
  logic [SUBW-1:0]                r_ptr;
  logic                           r_resp_ready;
  logic                           r_fill_valid;
  logic [ADDR_WIDTH-1:0]          r_fill_addr;
  logic [OPW-1:0]                 r_fill_op;
  logic [DATA_WIDTH-1:0]          r_fill_data;
  logic                           w_accept;
  logic                           w_last;

  // One read port: the responding entry while idle, the draining entry otherwise.
  assign o_rd_id  = (r_state == FILL_IDLE) ? i_resp_id : r_id;
  // Responses for entries that are not outstanding (e.g. stale after reset) are dropped.
  assign w_accept = (r_state == FILL_IDLE) && i_resp_valid && i_rd_entry.valid && i_rd_entry.issued;
  assign w_last   = (r_state == FILL_DRAIN) && ((CNTW'(r_ptr) + CNTW'(1)) == i_rd_entry.count);

  assign o_busy       = w_accept || (r_state == FILL_DRAIN);
  assign o_free_stb   = w_last;
  assign o_resp_ready = r_resp_ready;
  assign o_fill_valid = r_fill_valid;
  assign o_fill_addr  = r_fill_addr;
  assign o_fill_op    = r_fill_op;
  assign o_fill_data  = r_fill_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FILL_IDLE;
      r_id         <= '0;
      r_data       <= '0;
      r_ptr        <= '0;
      r_resp_ready <= 1'b1;
      r_fill_valid <= 1'b0;
      r_fill_addr  <= '0;
      r_fill_op    <= '0;
      r_fill_data  <= '0;
    end else begin
      case (r_state)
        FILL_IDLE: begin
          r_fill_valid <= 1'b0;
          if (w_accept) begin
            r_id         <= i_resp_id;
            r_data       <= i_resp_data;
            r_ptr        <= '0;
            r_state      <= FILL_DRAIN;
            r_resp_ready <= 1'b0;
          end
        end
        FILL_DRAIN: begin
          r_fill_valid <= 1'b1;
          r_fill_addr  <= {i_rd_entry.tag, i_rd_entry.index};
          r_fill_op    <= i_rd_entry.sub[r_ptr];
          r_fill_data  <= r_data;
          r_ptr        <= r_ptr + 1'b1;
          if (w_last) begin
            r_state      <= FILL_IDLE;
            r_resp_ready <= 1'b1;
          end
        end
        default: r_state <= FILL_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mshr_file.sv
// Miss-status holding register file: merges secondary misses per block,
// issues one memory read per block and replays fills in arrival order.
module mshr_file
  import mshr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = ADDR_WIDTH_D,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_D,
  parameter int unsigned NUM_BLOCKS     = NUM_BLOCKS_D,
  parameter int unsigned NUM_OPS        = NUM_OPS_D,
  parameter int unsigned NUM_ENTRIES    = NUM_ENTRIES_D,
  parameter int unsigned NUM_SUBENTRIES = NUM_SUBENTRIES_D
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      req_valid,
  input  logic [$clog2(NUM_OPS)-1:0]                req_op,
  input  logic [ADDR_WIDTH-$clog2(NUM_BLOCKS)-1:0]  req_tag,
  input  logic [$clog2(NUM_BLOCKS)-1:0]             req_index,
  output logic                                      req_ack,
  output logic                                      full,
  output logic                                      mem_req_valid,
  output logic [ADDR_WIDTH-1:0]                     mem_req_addr,
  output logic [$clog2(NUM_ENTRIES)-1:0]            mem_req_id,
  input  logic                                      mem_req_ready,
  input  logic                                      mem_resp_valid,
  input  logic [$clog2(NUM_ENTRIES)-1:0]            mem_resp_id,
  input  logic [DATA_WIDTH-1:0]                     mem_resp_data,
  output logic                                      mem_resp_ready,
  output logic                                      fill_valid,
  output logic [ADDR_WIDTH-1:0]                     fill_address,
  output logic [$clog2(NUM_OPS)-1:0]                fill_op,
  output logic [DATA_WIDTH-1:0]                     fill_data
);

  localparam int unsigned EW = $clog2(NUM_ENTRIES);

  mshr_entry_t     r_tbl     [NUM_ENTRIES];
  mshr_entry_t     w_tbl_nxt [NUM_ENTRIES];
  mshr_entry_t     w_rd_entry;

  logic            r_pend_valid;
  logic [OPW-1:0]  r_pend_op;
  logic [TAGW-1:0] r_pend_tag;
  logic [IDXW-1:0] r_pend_idx;
  logic            r_ack;
  logic            r_full;
  logic            r_mem_req_valid;
  logic [ADDR_WIDTH-1:0] r_mem_req_addr;
  logic [EW-1:0]   r_mem_req_id;

  logic            w_match_hit, w_free_hit, w_cand_hit;
  logic [EW-1:0]   w_match_id, w_free_id, w_cand_id, w_rd_id;
  logic            w_issue_acc, w_ack, w_all_valid, w_busy, w_free_stb;

  assign w_issue_acc = r_mem_req_valid && mem_req_ready;
  assign w_rd_entry  = r_tbl[w_rd_id];

  always_comb begin
    w_match_hit = 1'b0;
    w_match_id  = '0;
    w_free_hit  = 1'b0;
    w_free_id   = '0;
    w_cand_hit  = 1'b0;
    w_cand_id   = '0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      if (r_tbl[i].valid && r_tbl[i].tag == r_pend_tag && r_tbl[i].index == r_pend_idx) begin
        w_match_hit = 1'b1;
        w_match_id  = EW'(i);
      end
    end
    // Descending scans leave the lowest qualifying index selected.
    for (int unsigned i = NUM_ENTRIES; i > 0; i--) begin
      if (!r_tbl[i-1].valid) begin
        w_free_hit = 1'b1;
        w_free_id  = EW'(i-1);
      end
      if (r_tbl[i-1].valid && !r_tbl[i-1].issued && !(w_issue_acc && r_mem_req_id == EW'(i-1))) begin
        w_cand_hit = 1'b1;
        w_cand_id  = EW'(i-1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) w_tbl_nxt[i] = r_tbl[i];
    w_ack = 1'b0;
    if (w_issue_acc) w_tbl_nxt[r_mem_req_id].issued = 1'b1;
    if (w_free_stb)  w_tbl_nxt[w_rd_id].valid = 1'b0;
    // An entry whose response is latched or draining takes no more merges; the request waits for reallocation.
    if (r_pend_valid) begin
      if (w_match_hit) begin
        if (!(w_busy && w_rd_id == w_match_id) && r_tbl[w_match_id].count < CNTW'(NUM_SUBENTRIES)) begin
          w_tbl_nxt[w_match_id].sub[r_tbl[w_match_id].count[SUBW-1:0]] = r_pend_op;
          w_tbl_nxt[w_match_id].count = r_tbl[w_match_id].count + 1'b1;
          w_ack = 1'b1;
        end
      end else if (w_free_hit) begin
        w_tbl_nxt[w_free_id]        = '0;
        w_tbl_nxt[w_free_id].valid  = 1'b1;
        w_tbl_nxt[w_free_id].tag    = r_pend_tag;
        w_tbl_nxt[w_free_id].index  = r_pend_idx;
        w_tbl_nxt[w_free_id].count  = CNTW'(1);
        w_tbl_nxt[w_free_id].sub[0] = r_pend_op;
        w_ack = 1'b1;
      end
    end
    w_all_valid = 1'b1;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) w_all_valid = w_all_valid & w_tbl_nxt[i].valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_tbl[i] <= '0;
      r_pend_valid <= 1'b0;
      r_pend_op    <= '0;
      r_pend_tag   <= '0;
      r_pend_idx   <= '0;
      r_ack        <= 1'b0;
      r_full       <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) r_tbl[i] <= w_tbl_nxt[i];
      if (req_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_op    <= req_op;
        r_pend_tag   <= req_tag;
        r_pend_idx   <= req_index;
      end else if (w_ack) begin
        r_pend_valid <= 1'b0;
      end
      r_ack  <= w_ack;
      r_full <= w_all_valid;
    end
  end

  // Presented request is frozen until accepted, so a lower entry allocated meanwhile cannot displace it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_req_valid <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_id    <= '0;
    end else if (!r_mem_req_valid || mem_req_ready) begin
      r_mem_req_valid <= w_cand_hit;
      if (w_cand_hit) begin
        r_mem_req_id   <= w_cand_id;
        r_mem_req_addr <= {r_tbl[w_cand_id].tag, r_tbl[w_cand_id].index};
      end
    end
  end

  mshr_fill_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_fill (
    .clk          (clk),
    .reset        (reset),
    .i_resp_valid (mem_resp_valid),
    .i_resp_id    (mem_resp_id),
    .i_resp_data  (mem_resp_data),
    .o_resp_ready (mem_resp_ready),
    .o_rd_id      (w_rd_id),
    .i_rd_entry   (w_rd_entry),
    .o_busy       (w_busy),
    .o_free_stb   (w_free_stb),
    .o_fill_valid (fill_valid),
    .o_fill_addr  (fill_address),
    .o_fill_op    (fill_op),
    .o_fill_data  (fill_data)
  );

  assign req_ack       = r_ack;
  assign full          = r_full;
  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_mem_req_addr;
  assign mem_req_id    = r_mem_req_id;

endmodule

// File: tb/tb_mshr_file.sv
// Directed bench for mshr_file: expected memory requests and fills are queued
// by the stimulus and popped by a monitor as the DUT presents them.
module tb_mshr_file;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [4:0]  req_op;
  logic [12:0] req_tag;
  logic [2:0]  req_index;
  logic        req_ack;
  logic        full;
  logic        mem_req_valid;
  logic [15:0] mem_req_addr;
  logic [1:0]  mem_req_id;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [1:0]  mem_resp_id;
  logic [31:0] mem_resp_data;
  logic        mem_resp_ready;
  logic        fill_valid;
  logic [15:0] fill_address;
  logic [4:0]  fill_op;
  logic [31:0] fill_data;

  always #5 clk = ~clk;

  mshr_file dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_tag        (req_tag),
    .req_index      (req_index),
    .req_ack        (req_ack),
    .full           (full),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_id     (mem_req_id),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_id    (mem_resp_id),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_ready (mem_resp_ready),
    .fill_valid     (fill_valid),
    .fill_address   (fill_address),
    .fill_op        (fill_op),
    .fill_data      (fill_data)
  );

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  id;
  } mreq_t;

  typedef struct {
    logic [15:0] addr;
    logic [4:0]  op;
    logic [31:0] data;
  } fill_t;

  mreq_t exp_mreq[$];
  fill_t exp_fill[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: accepted memory requests and fills are compared against the queues.
  always @(negedge clk) begin
    if (mem_req_valid === 1'b1 && mem_req_ready === 1'b1) begin
      if (exp_mreq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mreq_unexpected: got addr 0x%0h id %0d, expected none", mem_req_addr, mem_req_id);
      end else begin
        mreq_t e;
        e = exp_mreq.pop_front();
        check("mreq_addr", 64'(mem_req_addr), 64'(e.addr));
        check("mreq_id", 64'(mem_req_id), 64'(e.id));
      end
    end
    if (fill_valid === 1'b1) begin
      if (exp_fill.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fill_unexpected: got addr 0x%0h op %0d, expected none", fill_address, fill_op);
      end else begin
        fill_t f;
        f = exp_fill.pop_front();
        check("fill_address", 64'(fill_address), 64'(f.addr));
        check("fill_op", 64'(fill_op), 64'(f.op));
        check("fill_data", 64'(fill_data), 64'(f.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [4:0] op, input logic [12:0] tag, input logic [2:0] idx);
    req_valid = 1'b1;
    req_op    = op;
    req_tag   = tag;
    req_index = idx;
    tick();
    req_valid = 1'b0;
  endtask

  // lat counts clock edges from the one that captured req_valid to the one that raised req_ack.
  task automatic wait_ack(input string name, input int budget, output int lat);
    bit done;
    done = 1'b0;
    lat  = 1;
    while (!done) begin
      @(negedge clk);
      if (req_ack === 1'b1) done = 1'b1;
      else if (lat >= budget) begin
        check({name, "_ack_timeout"}, 64'(req_ack), 64'd1);
        done = 1'b1;
      end else lat++;
    end
    tick();
  endtask

  task automatic send_req(input string name, input logic [4:0] op, input logic [12:0] tag,
                          input logic [2:0] idx, input bit chk_lat);
    int lat;
    pulse_req(op, tag, idx);
    wait_ack(name, 20, lat);
    if (chk_lat) check({name, "_ack_latency"}, 64'(lat), 64'd2);
  endtask

  task automatic send_resp(input logic [1:0] id, input logic [31:0] data);
    int n;
    n = 0;
    while (mem_resp_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("mem_resp_ready_before_resp", 64'(mem_resp_ready), 64'd1);
    mem_resp_valid = 1'b1;
    mem_resp_id    = id;
    mem_resp_data  = data;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_fill.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 64'(exp_fill.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic no_ack_window(input string name);
    logic seen;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | req_ack;
    end
    check({name, "_held_no_ack"}, 64'(seen), 64'd0);
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] t3_addr [4];
  int          lat;

  initial begin
    t3_addr[0] = 16'h0100;
    t3_addr[1] = 16'h0109;
    t3_addr[2] = 16'h0112;
    t3_addr[3] = 16'h011B;

    reset          = 1'b1;
    req_valid      = 1'b0;
    req_op         = '0;
    req_tag        = '0;
    req_index      = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_id    = '0;
    mem_resp_data  = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_req_ack", 64'(req_ack), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst_mem_req_addr", 64'(mem_req_addr), 64'd0);
    check("rst_mem_req_id", 64'(mem_req_id), 64'd0);
    check("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd1);
    check("rst_fill_valid", 64'(fill_valid), 64'd0);
    check("rst_fill_address", 64'(fill_address), 64'd0);
    check("rst_fill_op", 64'(fill_op), 64'd0);
    check("rst_fill_data", 64'(fill_data), 64'd0);

    // Single miss
    exp_mreq.push_back('{16'h0095, 2'd0});
    send_req("t1", 5'd3, 13'h012, 3'd5, 1'b1);
    repeat (3) tick();
    exp_fill.push_back('{16'h0095, 5'd3, 32'hDEADBEEF});
    send_resp(2'd0, 32'hDEADBEEF);
    wait_drain("t1");
    check("t1_full_after_free", 64'(full), 64'd0);

    // Secondary misses merge into one memory read
    exp_mreq.push_back('{16'h0095, 2'd0});
    send_req("t2a", 5'd3, 13'h012, 3'd5, 1'b1);
    send_req("t2b", 5'd7, 13'h012, 3'd5, 1'b1);
    send_req("t2c", 5'd9, 13'h012, 3'd5, 1'b1);
    repeat (3) tick();
    exp_fill.push_back('{16'h0095, 5'd3, 32'hCAFEF00D});
    exp_fill.push_back('{16'h0095, 5'd7, 32'hCAFEF00D});
    exp_fill.push_back('{16'h0095, 5'd9, 32'hCAFEF00D});
    send_resp(2'd0, 32'hCAFEF00D);
    wait_drain("t2");

    // Four distinct blocks fill the table; a fifth waits for a free entry
    for (int i = 0; i < 4; i++) begin
      exp_mreq.push_back('{t3_addr[i], 2'(i)});
      send_req("t3", 5'(16 + i), 13'(32 + i), 3'(i), 1'b1);
    end
    repeat (3) tick();
    check("t3_full_set", 64'(full), 64'd1);
    pulse_req(5'd24, 13'h030, 3'd6);
    no_ack_window("t3_fifth");
    exp_mreq.push_back('{16'h0186, 2'd0});
    exp_fill.push_back('{t3_addr[0], 5'd16, 32'h30000000});
    send_resp(2'd0, 32'h30000000);
    wait_ack("t3_fifth", 20, lat);
    check("t3_alloc_after_free_latency", 64'(lat), 64'd3);
    repeat (3) tick();
    check("t3_full_again", 64'(full), 64'd1);
    for (int i = 1; i < 4; i++) begin
      exp_fill.push_back('{t3_addr[i], 5'(16 + i), 32'(32'h30000000 + i)});
      send_resp(2'(i), 32'(32'h30000000 + i));
      wait_drain("t3_blk");
    end
    exp_fill.push_back('{16'h0186, 5'd24, 32'h3000FFFF});
    send_resp(2'd0, 32'h3000FFFF);
    wait_drain("t3_last");
    check("t3_full_cleared", 64'(full), 64'd0);

    // Subentries exhausted: fifth op waits for drain, then reallocates
    exp_mreq.push_back('{16'h0202, 2'd0});
    for (int i = 0; i < 4; i++) send_req("t4", 5'(10 + i), 13'h040, 3'd2, 1'b1);
    repeat (3) tick();
    pulse_req(5'd14, 13'h040, 3'd2);
    no_ack_window("t4_fifth");
    exp_mreq.push_back('{16'h0202, 2'd0});
    for (int i = 0; i < 4; i++) exp_fill.push_back('{16'h0202, 5'(10 + i), 32'h44440000});
    send_resp(2'd0, 32'h44440000);
    wait_ack("t4_fifth", 30, lat);
    check("t4_realloc_latency", 64'(lat), 64'd6);
    repeat (3) tick();
    exp_fill.push_back('{16'h0202, 5'd14, 32'h44441111});
    send_resp(2'd0, 32'h44441111);
    wait_drain("t4");

    // Memory back-pressure: presented request stays stable
    mem_req_ready = 1'b0;
    send_req("t5", 5'd20, 13'h055, 3'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_valid", 64'(mem_req_valid), 64'd1);
      check("t5_stall_addr", 64'(mem_req_addr), 64'h02AF);
      check("t5_stall_id", 64'(mem_req_id), 64'd0);
    end
    tick();
    exp_mreq.push_back('{16'h02AF, 2'd0});
    mem_req_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t5_valid_drops_after_accept", 64'(mem_req_valid), 64'd0);
    tick();
    exp_fill.push_back('{16'h02AF, 5'd20, 32'h55555555});
    send_resp(2'd0, 32'h55555555);
    wait_drain("t5");

    // Reset after the first of three fills
    exp_mreq.push_back('{16'h0333, 2'd0});
    send_req("t6a", 5'd1, 13'h066, 3'd3, 1'b0);
    send_req("t6b", 5'd2, 13'h066, 3'd3, 1'b0);
    send_req("t6c", 5'd3, 13'h066, 3'd3, 1'b0);
    repeat (3) tick();
    exp_fill.push_back('{16'h0333, 5'd1, 32'h66666666});
    send_resp(2'd0, 32'h66666666);
    tick();
    reset = 1'b1;
    tick();
    check("t6_fill_valid_after_reset", 64'(fill_valid), 64'd0);
    tick();
    reset = 1'b0;
    check("t6_full_after_reset", 64'(full), 64'd0);
    check("t6_resp_ready_after_reset", 64'(mem_resp_ready), 64'd1);
    check("t6_mreq_valid_after_reset", 64'(mem_req_valid), 64'd0);
    check("t6_fill_queue_after_reset", 64'(exp_fill.size()), 64'd0);
    send_resp(2'd0, 32'hBAD0BAD0);
    repeat (6) tick();
    exp_mreq.push_back('{16'h03B9, 2'd0});
    send_req("t6_new", 5'd4, 13'h077, 3'd1, 1'b1);
    repeat (3) tick();
    exp_fill.push_back('{16'h03B9, 5'd4, 32'h77777777});
    send_resp(2'd0, 32'h77777777);
    wait_drain("t6_new");

    check("mreq_queue_empty", 64'(exp_mreq.size()), 64'd0);
    check("fill_queue_empty", 64'(exp_fill.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mshr_file.md
Name: mshr_file

Overview:
- Miss-status holding register file directly downstream of the non-blocking direct-mapped cache.
- Accepts miss requests (op, tag, index) from the cache and merges secondary misses to an outstanding block.
- Issues one memory read per distinct block.
- On memory return, replays a fill into the cache once per merged op, in arrival order. The cache's write port is driven by these fills.

Parameters:
ADDR_WIDTH, 16, full block address width (tag+index)
DATA_WIDTH, 32, block data width
NUM_BLOCKS, 8, cache blocks; index width = $clog2(NUM_BLOCKS)
NUM_OPS, 32, op-ID space; op width = $clog2(NUM_OPS)
NUM_ENTRIES, 4, MSHR entries (distinct outstanding blocks)
NUM_SUBENTRIES, 4, ops mergeable per entry

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  cache miss request pulse
req_op  in  OPW  op ID of missing read
req_tag  in  ADDR_WIDTH-IDXW  tag
req_index  in  IDXW  index
req_ack  out  1  one-cycle pulse: request has been entered in table; drives cache received_request
full  out  1  no free entry (status only)
mem_req_valid  out  1  memory read request
mem_req_addr  out  ADDR_WIDTH  {tag,index}
mem_req_id  out  $clog2(NUM_ENTRIES)  entry number
mem_req_ready  in  1  memory accepts request this cycle
mem_resp_valid  in  1  memory data return
mem_resp_id  in  $clog2(NUM_ENTRIES)  entry number being returned
mem_resp_data  in  DATA_WIDTH  block data
mem_resp_ready  out  1  high only when fill FSM is IDLE
fill_valid  out  1  cache write_enable
fill_address  out  ADDR_WIDTH  cache w_address ({tag,index})
fill_op  out  OPW  cache w_op
fill_data  out  DATA_WIDTH  cache write_data

Behaviour:
- Reset: all entries invalid; pending register empty.
- Reset output values: req_ack=0, full=0, mem_req_valid=0, mem_req_addr/id=0, mem_resp_ready=1, fill_valid=0, fill_address/op/data=0.
- Reset is synchronous; reset mid-drain or mid-issue abandons all state. Memory responses arriving after reset are ignored.
- Input stage: req_valid captured into a 1-deep pending register. The cache sends no new request until req_ack, so pending never overflows.
- Each cycle, a pending request resolves in priority order:
  (a) Matches valid entry not in DRAIN with subentry count < NUM_SUBENTRIES: append op, count++, clear pending, req_ack next cycle.
  (b) Matches entry being drained, or matching entry's subentries are full: hold (no ack).
  (c) No match and a free entry exists: allocate the lowest free index with valid=1, issued=0, count=1, sub[0]=op; ack.
  (d) Otherwise hold; the hold clears when an entry frees.
- Total latency from req_valid to req_ack is 2 cycles when unobstructed.
- Issue:
  - Select the lowest entry with valid && !issued and drive mem_req_*.
  - Hold the selected request stable until mem_req_ready; on that cycle set issued=1.
  - mem_req_valid drops or moves to the next candidate the following cycle.
- Fill FSM:
  - States IDLE and DRAIN.
  - IDLE: on mem_resp_valid, latch id/data, set sub pointer=0, go to DRAIN.
  - DRAIN: each cycle drive fill_valid=1 with fill_op=sub[ptr], fill_address={tag,index}, fill_data=latched data, then ptr++.
  - After the fill for ptr==count-1: free the entry (valid=0) and return to IDLE.
  - A count-N entry produces exactly N back-to-back fills, arrival order preserved.
- Simultaneous events:
  - Same-cycle free and allocate: the freed entry may be allocated next cycle, not the same cycle.
  - Merge into an entry in IDLE-but-issued state is allowed until mem_resp for that entry is latched.
  - A merge and a response latch for the same entry in the same cycle: the response wins; the request is held, then allocates a new entry.
- full = no entry with valid==0 (combinational from entry state, registered output).
- Widths: OPW=$clog2(NUM_OPS), IDXW=$clog2(NUM_BLOCKS); count is $clog2(NUM_SUBENTRIES+1) bits.

Decomposition:
- Package mshr_pkg: OPW/IDXW/TAGW localparams derived from shared defaults, and the mshr_entry_t struct (valid, issued, tag, index, count, sub-op array).
- One sub-module mshr_fill_fsm: response latch plus IDLE/DRAIN sequencer. It reads entry contents via index and returns a free strobe.
- Table, matching, allocation and issue stay in the top module.

Test Plan:
- Reset, then req op=3 tag=0x12 idx=5:
  - req_ack two cycles later.
  - mem_req addr=0x0095 id=0.
  - mem_resp id=0 data=0xDEADBEEF -> one fill: address 0x0095, op 3, data 0xDEADBEEF; entry freed, full=0.
- Secondary misses: ops 3, 7, 9 to tag=0x12 idx=5 before the response:
  - Exactly one mem_req.
  - On response, three consecutive fills with ops 3, 7, 9 and the same data.
- Four distinct blocks allocated -> full=1.
  - A fifth distinct request is not acked until the first response drains.
  - It then allocates entry 0 and acks.
- Entry with 4 merged ops plus a 5th matching request:
  - No ack until drain completes.
  - The 5th then gets a new entry and a new mem_req.
- mem_req_ready held low 5 cycles -> mem_req_valid/addr/id stable throughout; issued only after ready.
- Assert reset during DRAIN after 1 of 3 fills -> fill_valid=0 next cycle, all entries invalid, no further fills.
